// File: rtl/mux_2to1_rr_arbiter.sv
// Two-requester round-robin arbiter driving a 2:1 mux into one registered valid/ready output stage.
// Define PACKET_LOCK_EN to hold the grant on one source from a first beat until its last beat.
module mux_2to1_rr_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             iClk,
  input  logic             iRstn,
  input  logic             iAValid,
  input  logic [WIDTH-1:0] iAData,
  input  logic             iALast,
  output logic             oAReady,
  input  logic             iBValid,
  input  logic [WIDTH-1:0] iBData,
  input  logic             iBLast,
  output logic             oBReady,
  output logic             oValid,
  output logic [WIDTH-1:0] oData,
  output logic             oLast,
  output logic             oSel,
  input  logic             iReady
);

  logic             wLoad;
  logic             grant_a;
  logic             grant_b;
  logic             rLastSel;
  logic [WIDTH-1:0] sel_data;
  logic             sel_last;

`ifdef PACKET_LOCK_EN
  logic rLock;
`else
  logic rLock;
  assign rLock = 1'b0;
`endif

  assign wLoad = !oValid | iReady;

  // Round-robin by default; an open packet pins the grant to its source.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (iAValid & iBValid) begin
      grant_a = rLastSel;
      grant_b = !rLastSel;
    end else begin
      grant_a = iAValid;
      grant_b = iBValid;
    end
    if (rLock) begin
      grant_a = !rLastSel & iAValid;
      grant_b = rLastSel & iBValid;
    end
  end

  assign oAReady  = wLoad & grant_a;
  assign oBReady  = wLoad & grant_b;
  assign sel_data = grant_b ? iBData : iAData;
  assign sel_last = grant_b ? iBLast : iALast;

  // Output stage: load on accept, empty when free and idle, hold under backpressure.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      oValid   <= 1'b0;
      oData    <= '0;
      oLast    <= 1'b0;
      oSel     <= 1'b0;
      rLastSel <= 1'b1;
`ifdef PACKET_LOCK_EN
      rLock    <= 1'b0;
`endif
    end else if (wLoad) begin
      if (grant_a | grant_b) begin
        oValid   <= 1'b1;
        oData    <= sel_data;
        oLast    <= sel_last;
        oSel     <= grant_b;
        rLastSel <= grant_b;
`ifdef PACKET_LOCK_EN
        rLock    <= !sel_last;
`endif
      end else begin
        oValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_2to1_rr_arbiter.sv
// Bench for mux_2to1_rr_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mux_2to1_rr_arbiter;

  logic       iClk = 1'b0;
  logic       iRstn = 1'b0;
  logic       iAValid = 1'b0;
  logic [7:0] iAData = 8'h00;
  logic       iALast = 1'b0;
  logic       oAReady;
  logic       iBValid = 1'b0;
  logic [7:0] iBData = 8'h00;
  logic       iBLast = 1'b0;
  logic       oBReady;
  logic       oValid;
  logic [7:0] oData;
  logic       oLast;
  logic       oSel;
  logic       iReady = 1'b0;

  int checks = 0;
  int errors = 0;

  // Model state: what the output stage must hold, whose turn a tie is, which source owns an open packet.
  bit       m_valid;
  bit [7:0] m_data;
  bit       m_last;
  bit       m_sel;
  int       turn;
  int       owner;
  bit       acc_a;
  bit       acc_b;

  mux_2to1_rr_arbiter #(.WIDTH(8)) dut (
    .iClk(iClk), .iRstn(iRstn),
    .iAValid(iAValid), .iAData(iAData), .iALast(iALast), .oAReady(oAReady),
    .iBValid(iBValid), .iBData(iBData), .iBLast(iBLast), .oBReady(oBReady),
    .oValid(oValid), .oData(oData), .oLast(oLast), .oSel(oSel), .iReady(iReady)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Which requester must be served this cycle: -1 none, 0 A, 1 B.
  function automatic int pick();
    if (owner == 0) return iAValid ? 0 : -1;
    if (owner == 1) return iBValid ? 1 : -1;
    if (iAValid && iBValid) return turn;
    if (iAValid) return 0;
    if (iBValid) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_last = 0; m_sel = 0;
    turn = 0; owner = -1; acc_a = 0; acc_b = 0;
  endtask

  // One clock: check readies before the edge, advance the model, check outputs after the edge.
  task automatic step();
    int g;
    bit room;
    #1;
    room = !m_valid || iReady;
    g = room ? pick() : -1;
    chk("a_ready", {31'b0, oAReady}, {31'b0, g == 0});
    chk("b_ready", {31'b0, oBReady}, {31'b0, g == 1});
    @(posedge iClk);
    acc_a = (g == 0);
    acc_b = (g == 1);
    if (room) begin
      if (g >= 0) begin
        m_valid = 1;
        m_data  = (g == 1) ? iBData : iAData;
        m_last  = (g == 1) ? iBLast : iALast;
        m_sel   = (g == 1);
        turn    = 1 - g;
`ifdef PACKET_LOCK_EN
        owner   = m_last ? -1 : g;
`endif
      end else begin
        m_valid = 0;
      end
    end
    #1;
    chk("out_valid", {31'b0, oValid}, {31'b0, m_valid});
    chk("out_data",  {24'b0, oData},  {24'b0, m_data});
    chk("out_last",  {31'b0, oLast},  {31'b0, m_last});
    chk("out_sel",   {31'b0, oSel},   {31'b0, m_sel});
  endtask

  task automatic do_reset();
    iRstn = 0; iAValid = 0; iBValid = 0; iReady = 0;
    #1;
    model_reset();
    chk("rst_valid", {31'b0, oValid}, 32'd0);
    chk("rst_data",  {24'b0, oData},  32'd0);
    chk("rst_last",  {31'b0, oLast},  32'd0);
    chk("rst_sel",   {31'b0, oSel},   32'd0);
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    iRstn = 1;
  endtask

  initial begin
    bit [1:0] sels [4];
    bit [1:0] exp_sels [4];
    bit [7:0] exp_d [4];
    int a_sent;

    do_reset();

    // A alone
    iAValid = 1; iAData = 8'h11; iALast = 1; iReady = 1;
    #1;
    chk("t1_b_ready", {31'b0, oBReady}, 32'd0);
    step();
    chk("t1_valid", {31'b0, oValid}, 32'd1);
    chk("t1_data",  {24'b0, oData},  32'h11);
    chk("t1_sel",   {31'b0, oSel},   32'd0);

    // Idle cycle drains the register but leaves data in place
    iAValid = 0;
    step();
    chk("t6_valid", {31'b0, oValid}, 32'd0);
    chk("t6_data",  {24'b0, oData},  32'h11);

    // Both requesters continuously
    do_reset();
    exp_d = '{8'hAA, 8'hBB, 8'hAA, 8'hBB};
    iAValid = 1; iAData = 8'hAA; iALast = 1;
    iBValid = 1; iBData = 8'hBB; iBLast = 1; iReady = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_data", {24'b0, oData}, {24'b0, exp_d[i]});
      chk("t2_sel",  {31'b0, oSel},  i % 2);
    end

    // Backpressure holds the beat
    iBValid = 0; iAData = 8'h22;
    step();
    chk("t3_first", {24'b0, oData}, 32'h22);
    iAData = 8'h33; iReady = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_hold",  {24'b0, oData}, 32'h22);
      chk("t3_ready", {30'b0, oAReady, oBReady}, 32'd0);
    end
    iReady = 1;
    step();
    chk("t3_release", {24'b0, oData}, 32'h33);

    // Three-beat packet from A against a steady B
    do_reset();
`ifdef PACKET_LOCK_EN
    exp_sels = '{2'd0, 2'd0, 2'd0, 2'd1};
`else
    exp_sels = '{2'd0, 2'd1, 2'd0, 2'd1};
`endif
    a_sent = 0;
    iBValid = 1; iBData = 8'hB0; iBLast = 1; iReady = 1;
    for (int i = 0; i < 4; i++) begin
      iAValid = (a_sent < 3);
      iAData  = 8'hA0 + 8'(a_sent);
      iALast  = (a_sent == 2);
      step();
      if (acc_a) a_sent++;
      sels[i] = {1'b0, oSel};
    end
    for (int i = 0; i < 4; i++) chk("t4_order", {30'b0, sels[i]}, {30'b0, exp_sels[i]});

    // Reset in the middle of traffic
    do_reset();
    iAValid = 1; iAData = 8'h5A; iALast = 1;
    iBValid = 1; iBData = 8'hB5; iBLast = 1; iReady = 1;
    step(); step();
    chk("t5_pre_valid", {31'b0, oValid}, 32'd1);
    chk("t5_pre_sel",   {31'b0, oSel},   32'd1);
    iRstn = 0;
    #1;
    model_reset();
    chk("t5_valid", {31'b0, oValid}, 32'd0);
    chk("t5_sel",   {31'b0, oSel},   32'd0);
    @(negedge iClk);
    iRstn = 1;
    step();
    chk("t5_first_sel",  {31'b0, oSel},  32'd0);
    chk("t5_first_data", {24'b0, oData}, 32'h5A);

    // Randomized traffic; producers keep a beat presented until it is taken
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (!iAValid || acc_a) begin
        iAValid = ($urandom_range(0, 3) != 0);
        iAData  = 8'($urandom);
        iALast  = ($urandom_range(0, 2) == 0);
      end
      if (!iBValid || acc_b) begin
        iBValid = ($urandom_range(0, 3) != 0);
        iBData  = 8'($urandom);
        iBLast  = ($urandom_range(0, 2) == 0);
      end
      iReady = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
